// File: rtl/led_count_pkg.sv
// Shared types and helpers for the LED counter bank: channel mode encoding
// and the load channel-select width.
package led_count_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        HOLD   = 2'b00,
        UP     = 2'b01,
        DOWN   = 2'b10,
        BOUNCE = 2'b11
    } mode_t;

    // Width of a channel index; a single-channel bank still gets one select bit.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_count_chan.sv
// One counter channel: up/down/bounce counter with direction flag, wrap
// detection, and the registered LED field / wrap pulse taken from it.
module led_count_chan import led_count_pkg::*; #(
    parameter int CNT_W   = 32,
    parameter int LED_W   = 8,
    parameter int LED_LSB = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  mode_t            mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [LED_W-1:0] led,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_down;
    logic             dir_nxt;
    logic             wrap_evt;
    logic             wrap_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir_down;
        wrap_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_value;
            dir_nxt = 1'b0;
        end else if (en) begin
            case (mode)
                UP: begin
                    cnt_nxt  = cnt + ONE;
                    wrap_nxt = (cnt == MAX);
                end
                DOWN: begin
                    cnt_nxt  = cnt - ONE;
                    wrap_nxt = (cnt == '0);
                end
                BOUNCE: begin
                    // Reverse at the rails without overshooting them.
                    if (!dir_down) begin
                        if (cnt == MAX) begin
                            cnt_nxt  = cnt - ONE;
                            dir_nxt  = 1'b1;
                            wrap_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + ONE;
                        end
                    end else begin
                        if (cnt == '0) begin
                            cnt_nxt  = ONE;
                            dir_nxt  = 1'b0;
                            wrap_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // wrap_evt lines up with the counter; wrap lines up with the LED field.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            dir_down <= 1'b0;
            wrap_evt <= 1'b0;
            led      <= '0;
            wrap     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            dir_down <= dir_nxt;
            wrap_evt <= wrap_nxt;
            led      <= cnt[LED_LSB +: LED_W];
            wrap     <= wrap_evt;
        end
    end

endmodule

// File: rtl/led_count_bank.sv
// Bank of NUM_CH LED counters with a shared load port and optional PWM
// brightness ramp (enabled by defining LED_COUNT_BANK_PWM_EN).
module led_count_bank import led_count_pkg::*; #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int LED_W   = 8,
    parameter int LED_LSB = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_CH-1:0]          enable,
    input  logic [MODE_W*NUM_CH-1:0]   mode,
    input  logic                       load_valid,
    input  logic [sel_w(NUM_CH)-1:0]   load_ch,
    input  logic [CNT_W-1:0]           load_value,
    output logic                       load_ready,
    output logic [NUM_CH*LED_W-1:0]    led,
    output logic [NUM_CH-1:0]          wrap,
    output logic [NUM_CH-1:0]          pwm
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("led_count_bank: NUM_CH must be 1..16");
    end
    if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
        $error("led_count_bank: CNT_W must be 8..32");
    end
    if (LED_LSB + LED_W > CNT_W) begin : g_bad_led_field
        $error("led_count_bank: LED field exceeds counter width");
    end

    // Handshake: a load transfers on a rising edge where load_valid and
    // load_ready are both high; load_ready then drops for exactly one cycle.
    // Out-of-range load_ch values complete the handshake but touch nothing.
    logic load_fire;
    assign load_fire = load_valid && load_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) load_ready <= 1'b0;
        else     load_ready <= !load_fire;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_count_chan #(
            .CNT_W   (CNT_W),
            .LED_W   (LED_W),
            .LED_LSB (LED_LSB)
        ) u_chan (
            .CLK        (CLK),
            .RST        (RST),
            .en         (enable[i]),
            .mode       (mode_t'(mode[i*MODE_W +: MODE_W])),
            .load       (load_fire && (32'(load_ch) == i)),
            .load_value (load_value),
            .led        (led[i*LED_W +: LED_W]),
            .wrap       (wrap[i])
        );
    end

`ifdef LED_COUNT_BANK_PWM_EN
    localparam logic [LED_W-1:0] RAMP_STEP = LED_W'(1);

    logic [LED_W-1:0] ramp;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ramp <= '0;
            pwm  <= '0;
        end else begin
            ramp <= ramp + RAMP_STEP;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm[i] <= (ramp < led[i*LED_W +: LED_W]);
            end
        end
    end
`else
    assign pwm = '0;
`endif

endmodule

// File: tb/tb_led_count_bank.sv
// Directed bench for led_count_bank: a default-parameter bank plus a narrow
// 5-channel, 8-bit bank for bounce and out-of-range load selection.
module tb_led_count_bank;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    // Default-parameter instance
    logic [3:0]  en0   = '0;
    logic [7:0]  mode0 = '0;
    logic        lv0   = 1'b0;
    logic [1:0]  lch0  = '0;
    logic [31:0] lval0 = '0;
    logic        lr0;
    logic [31:0] led0;
    logic [3:0]  wrap0;
    logic [3:0]  pwm0;

    // Narrow instance: NUM_CH=5, CNT_W=8, LED_W=8, LED_LSB=0
    logic [4:0]  en1   = '0;
    logic [9:0]  mode1 = '0;
    logic        lv1   = 1'b0;
    logic [2:0]  lch1  = '0;
    logic [7:0]  lval1 = '0;
    logic        lr1;
    logic [39:0] led1;
    logic [4:0]  wrap1;
    logic [4:0]  pwm1;

    int total = 0;
    int bad   = 0;
    int hi0, hi_rest, nwrap;

`ifdef LED_COUNT_BANK_PWM_EN
    localparam int EXP_PWM_HI = 64;
`else
    localparam int EXP_PWM_HI = 0;
`endif

    led_count_bank dut0 (
        .CLK(CLK), .RST(RST), .enable(en0), .mode(mode0),
        .load_valid(lv0), .load_ch(lch0), .load_value(lval0),
        .load_ready(lr0), .led(led0), .wrap(wrap0), .pwm(pwm0)
    );

    led_count_bank #(.NUM_CH(5), .CNT_W(8), .LED_W(8), .LED_LSB(0)) dut1 (
        .CLK(CLK), .RST(RST), .enable(en1), .mode(mode1),
        .load_valid(lv1), .load_ch(lch1), .load_value(lval1),
        .load_ready(lr1), .led(led1), .wrap(wrap1), .pwm(pwm1)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held
        #3;
        chk("rst_lr0", 64'(lr0), 64'd0);
        chk("rst_led0", 64'(led0), 64'd0);
        chk("rst_wrap0", 64'(wrap0), 64'd0);
        chk("rst_pwm0", 64'(pwm0), 64'd0);
        tick();
        chk("rst_hold_lr0", 64'(lr0), 64'd0);
        #2 RST = 1'b0;
        tick();
        chk("rel_lr0", 64'(lr0), 64'd1);
        chk("rel_lr1", 64'(lr1), 64'd1);

        // Up wrap on ch0
        lv0 = 1'b1; lch0 = 2'd0; lval0 = 32'hFFFF_FFFE; en0 = 4'b0001; mode0 = 8'h01;
        tick();
        lv0 = 1'b0;
        chk("up_lr_low", 64'(lr0), 64'd0);
        tick();
        chk("up_lr_high", 64'(lr0), 64'd1);
        chk("up_led_fe", 64'(led0[7:0]), 64'hFF);
        chk("up_wrap_a", 64'(wrap0), 64'd0);
        tick();
        chk("up_led_ff", 64'(led0[7:0]), 64'hFF);
        chk("up_wrap_b", 64'(wrap0), 64'd0);
        tick();
        chk("up_led_0", 64'(led0[7:0]), 64'h00);
        chk("up_wrap_pulse", 64'(wrap0), 64'b0001);
        tick();
        chk("up_wrap_clear", 64'(wrap0), 64'd0);

        // Down wrap on ch1; ch0 disabled and holding
        lv0 = 1'b1; lch0 = 2'd1; lval0 = 32'h0; en0 = 4'b0010; mode0 = 8'h08;
        tick();
        lv0 = 1'b0;
        tick();
        chk("dn_led_0", 64'(led0[15:8]), 64'h00);
        chk("dn_wrap_a", 64'(wrap0), 64'd0);
        tick();
        chk("dn_led_ff", 64'(led0[15:8]), 64'hFF);
        chk("dn_wrap_pulse", 64'(wrap0), 64'b0010);
        chk("dn_ch0_hold", 64'(led0[7:0]), 64'h00);
        tick();
        chk("dn_wrap_clear", 64'(wrap0), 64'd0);

        // Back-to-back load requests
        en0 = 4'b0000;
        lv0 = 1'b1; lch0 = 2'd2; lval0 = 32'h00AB_0000;
        tick();
        chk("col_lr_e1", 64'(lr0), 64'd0);
        lch0 = 2'd3; lval0 = 32'h00CD_0000;
        tick();
        chk("col_lr_e2", 64'(lr0), 64'd1);
        chk("col_ch2_e2", 64'(led0[23:16]), 64'hAB);
        chk("col_ch3_e2", 64'(led0[31:24]), 64'h00);
        tick();
        lv0 = 1'b0;
        chk("col_lr_e3", 64'(lr0), 64'd0);
        chk("col_ch3_e3", 64'(led0[31:24]), 64'h00);
        tick();
        chk("col_ch3_e4", 64'(led0[31:24]), 64'hCD);
        chk("col_lr_e4", 64'(lr0), 64'd1);

        // Reset during the load_ready-low cycle, while counting
        en0 = 4'b0010; mode0 = 8'h08;
        lv0 = 1'b1; lch0 = 2'd0; lval0 = 32'h0000_0005;
        tick();
        lv0 = 1'b0;
        chk("mid_lr_low", 64'(lr0), 64'd0);
        chk("mid_led_pre", 64'(led0), 64'hCDAB_FF00);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_led", 64'(led0), 64'd0);
        chk("mid_rst_wrap", 64'(wrap0), 64'd0);
        chk("mid_rst_lr", 64'(lr0), 64'd0);
        #2 RST = 1'b0;
        en0 = 4'b0000;
        tick();
        chk("mid_rel_lr", 64'(lr0), 64'd1);
        tick();
        chk("mid_rel_led", 64'(led0), 64'd0);

        // PWM brightness with field 0x40 on ch0
        lv0 = 1'b1; lch0 = 2'd0; lval0 = 32'h0040_0000;
        tick();
        lv0 = 1'b0;
        tick();
        tick();
        chk("pwm_led", 64'(led0), 64'h0000_0040);
        hi0 = 0; hi_rest = 0;
        repeat (256) begin
            tick();
            hi0     += int'(pwm0[0]);
            hi_rest += $countones(pwm0[3:1]);
        end
        chk("pwm_ch0_hi", 64'(hi0), 64'(EXP_PWM_HI));
        chk("pwm_rest_hi", 64'(hi_rest), 64'd0);

        // Bounce on narrow ch2 from 0xFE
        lv1 = 1'b1; lch1 = 3'd2; lval1 = 8'hFE; en1 = 5'b00100; mode1 = 10'h030;
        tick();
        lv1 = 1'b0;
        tick();
        chk("bn_led_fe", 64'(led1[23:16]), 64'hFE);
        chk("bn_wrap_a", 64'(wrap1), 64'd0);
        tick();
        chk("bn_led_ff", 64'(led1[23:16]), 64'hFF);
        chk("bn_wrap_b", 64'(wrap1), 64'd0);
        tick();
        chk("bn_led_fe2", 64'(led1[23:16]), 64'hFE);
        chk("bn_wrap_rev", 64'(wrap1), 64'b00100);
        tick();
        chk("bn_led_fd", 64'(led1[23:16]), 64'hFD);
        chk("bn_wrap_clear", 64'(wrap1), 64'd0);

        // Load while heading down clears the direction flag
        lv1 = 1'b1; lval1 = 8'h01;
        tick();
        lv1 = 1'b0;
        tick();
        chk("bn_dir_led1", 64'(led1[23:16]), 64'h01);
        tick();
        chk("bn_dir_led2", 64'(led1[23:16]), 64'h02);

        // Full sweep from 0xFF down to the reversal at zero
        lv1 = 1'b1; lval1 = 8'hFF;
        tick();
        lv1 = 1'b0;
        nwrap = 0;
        repeat (256) begin
            tick();
            nwrap += int'(wrap1[2]);
        end
        chk("bn_sweep_wraps", 64'(nwrap), 64'd1);
        tick();
        chk("bn_zero_led", 64'(led1[23:16]), 64'h01);
        chk("bn_zero_wrap", 64'(wrap1), 64'b00100);
        tick();
        chk("bn_zero_led2", 64'(led1[23:16]), 64'h02);
        chk("bn_zero_clear", 64'(wrap1), 64'd0);

        // Disable, then mode HOLD while enabled
        en1 = 5'b00000;
        tick();
        chk("hold_en", 64'(led1), 64'h00_0003_0000);
        en1 = 5'b00100; mode1 = 10'h000;
        tick();
        tick();
        chk("hold_mode", 64'(led1), 64'h00_0003_0000);

        // Out-of-range channel is accepted and discarded
        en1 = 5'b00000;
        lv1 = 1'b1; lch1 = 3'd5; lval1 = 8'h55;
        tick();
        lv1 = 1'b0;
        chk("oor_lr_low", 64'(lr1), 64'd0);
        tick();
        chk("oor_lr_high", 64'(lr1), 64'd1);
        tick();
        chk("oor_no_change", 64'(led1), 64'h00_0003_0000);

        // Highest channel loads normally
        lv1 = 1'b1; lch1 = 3'd4; lval1 = 8'h77;
        tick();
        lv1 = 1'b0;
        tick();
        chk("top_ch_load", 64'(led1), 64'h77_0003_0000);
        chk("narrow_pwm", 64'(pwm1 & 5'b01011), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
